// File: rtl/apu_pkg.sv
// Shared types and constants for the APU square-channel register writer.
package apu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_e;

    localparam logic [2:0] REG_DUTY  = 3'd0;
    localparam logic [2:0] REG_SWEEP = 3'd1;
    localparam logic [2:0] REG_TLO   = 3'd2;
    localparam logic [2:0] REG_LEN   = 3'd3;
    localparam logic [2:0] CH2_BASE  = 3'd4;

    localparam logic [4:0] ADDR_PREFIX = 5'b00000;

    // Bit n set: a write to address n makes its channel reload (sweep and length regs).
    localparam logic [7:0] RELOAD_MASK = 8'b1010_1010;

    function automatic logic is_reload(input logic [2:0] addr);
        return RELOAD_MASK[addr];
    endfunction

    function automatic logic is_ch2(input logic [2:0] addr);
        return addr >= CH2_BASE;
    endfunction

endpackage

// File: rtl/apu_frame_timeout.sv
// Inter-byte timeout counter: counts enabled cycles and flags the LIMIT-th one.
module apu_frame_timeout #(
    parameter int unsigned LIMIT = 50000,
    parameter int unsigned W     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/apu_reg_writer.sv
// Host register writer for both APU square channels: address/data byte frames to 8 regs.
// Build option APU_WRITE_ANY_TOGGLE_EN: every write toggles its channel's reg_change.
module apu_reg_writer #(
    parameter int unsigned TIMEOUT_CYCLES = 16'd50000,
    parameter int unsigned TIMEOUT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] reg_4000,
    output logic [7:0] reg_4001,
    output logic [7:0] reg_4002,
    output logic [7:0] reg_4003,
    output logic [7:0] reg_4004,
    output logic [7:0] reg_4005,
    output logic [7:0] reg_4006,
    output logic [7:0] reg_4007,
    output logic       reg_change_1,
    output logic       reg_change_2,
    output logic       write_strobe,
    output logic       frame_error
);
    import apu_pkg::*;

    state_e          state_q, state_d;
    logic [2:0]      addr_q, addr_d;
    logic [7:0][7:0] regs_q;
    logic            chg1_q, chg2_q, ws_q, fe_q;
    logic            addr_ok, expire, wr_en, bad_addr, reload, tog1, tog2;

    assign addr_ok = (rx_data[7:3] == ADDR_PREFIX);

    apu_frame_timeout #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (TIMEOUT_W)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q == IDLE),
        .en_i     (state_q == DATA && !rx_valid),
        .expire_o (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: if (rx_valid && addr_ok) begin
                state_d = DATA;
                addr_d  = rx_data[2:0];
            end
            DATA: if (rx_valid || expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // expire is only raised on a cycle without rx_valid, so a late data byte always wins.
    always_comb begin
        wr_en    = (state_q == DATA) && rx_valid;
        bad_addr = (state_q == IDLE) && rx_valid && !addr_ok;
`ifdef APU_WRITE_ANY_TOGGLE_EN
        reload   = 1'b1;
`else
        reload   = is_reload(addr_q);
`endif
        tog1     = wr_en && reload && !is_ch2(addr_q);
        tog2     = wr_en && reload &&  is_ch2(addr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
            chg1_q <= 1'b0;
            chg2_q <= 1'b0;
            ws_q   <= 1'b0;
            fe_q   <= 1'b0;
        end else begin
            ws_q <= wr_en;
            fe_q <= bad_addr || expire;
            if (wr_en) regs_q[addr_q] <= rx_data;
            if (tog1)  chg1_q <= ~chg1_q;
            if (tog2)  chg2_q <= ~chg2_q;
        end
    end

    assign reg_4000     = regs_q[0];
    assign reg_4001     = regs_q[1];
    assign reg_4002     = regs_q[2];
    assign reg_4003     = regs_q[3];
    assign reg_4004     = regs_q[4];
    assign reg_4005     = regs_q[5];
    assign reg_4006     = regs_q[6];
    assign reg_4007     = regs_q[7];
    assign reg_change_1 = chg1_q;
    assign reg_change_2 = chg2_q;
    assign write_strobe = ws_q;
    assign frame_error  = fe_q;

endmodule

// File: tb/tb_apu_reg_writer.sv
// Bench for apu_reg_writer: frame table plus corner sequences, scoreboard on write_strobe.
module tb_apu_reg_writer;

`ifdef APU_WRITE_ANY_TOGGLE_EN
    localparam bit ANY = 1'b1;
`else
    localparam bit ANY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] reg_4000, reg_4001, reg_4002, reg_4003;
    logic [7:0] reg_4004, reg_4005, reg_4006, reg_4007;
    logic       reg_change_1, reg_change_2, write_strobe, frame_error;

    apu_reg_writer #(
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_W      (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .reg_4000     (reg_4000),
        .reg_4001     (reg_4001),
        .reg_4002     (reg_4002),
        .reg_4003     (reg_4003),
        .reg_4004     (reg_4004),
        .reg_4005     (reg_4005),
        .reg_4006     (reg_4006),
        .reg_4007     (reg_4007),
        .reg_change_1 (reg_change_1),
        .reg_change_2 (reg_change_2),
        .write_strobe (write_strobe),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic       f1;
        logic       f2;
    } vec_t;

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
        logic       t1;
        logic       t2;
        int         cyc;
    } exp_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         fe_cnt  = 0;
    int         last1   = -100;
    int         last2   = -100;
    logic       p1      = 1'b0;
    logic       p2      = 1'b0;
    exp_t       sb[$];
    logic [7:0] shadow[8];
    logic       mt1, mt2;
    vec_t       tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int i);
        case (i)
            0: return reg_4000;
            1: return reg_4001;
            2: return reg_4002;
            3: return reg_4003;
            4: return reg_4004;
            5: return reg_4005;
            6: return reg_4006;
            default: return reg_4007;
        endcase
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard, frame-error counter and toggle-spacing monitor.
    always @(negedge clk) begin
        if (write_strobe === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write_strobe", 32'(1), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("wr_cycle_a%0d", e.a), 32'(cyc), 32'(e.cyc));
                chk($sformatf("wr_data_a%0d", e.a), 32'(dut_reg(int'(e.a))), 32'(e.d));
                chk($sformatf("chg1_a%0d", e.a), 32'(reg_change_1), 32'(e.t1));
                chk($sformatf("chg2_a%0d", e.a), 32'(reg_change_2), 32'(e.t2));
            end
        end
        if (frame_error === 1'b1) fe_cnt++;
        if (rst) begin
            last1 = -100;
            last2 = -100;
        end else begin
            if (reg_change_1 !== p1) begin
                if (last1 >= 0) chk("chg1_spacing_ge3", 32'(cyc - last1 >= 3), 32'(1));
                last1 = cyc;
            end
            if (reg_change_2 !== p2) begin
                if (last2 >= 0) chk("chg2_spacing_ge3", 32'(cyc - last2 >= 3), 32'(1));
                last2 = cyc;
            end
        end
        p1 = reg_change_1;
        p2 = reg_change_2;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic data(input logic [2:0] a, input logic [7:0] d, input logic f1, input logic f2);
        exp_t e;
        shadow[a] = d;
        mt1 = mt1 ^ f1;
        mt2 = mt2 ^ f2;
        e.a = a; e.d = d; e.t1 = mt1; e.t2 = mt2; e.cyc = cyc + 1;
        sb.push_back(e);
        send(d);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic f1, input logic f2);
        send(a);
        data(a[2:0], d, f1, f2);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) shadow[i] = 8'h00;
        mt1 = 1'b0;
        mt2 = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_reg%0d", tag, i), 32'(dut_reg(i)), 32'(shadow[i]));
        chk({tag, "_chg1"}, 32'(reg_change_1), 32'(mt1));
        chk({tag, "_chg2"}, 32'(reg_change_2), 32'(mt2));
    endtask

    initial begin
        tbl[0] = '{8'h03, 8'hF9, 1'b1, 1'b0};
        tbl[1] = '{8'h06, 8'h55, 1'b0, ANY};
        tbl[2] = '{8'h01, 8'h12, 1'b1, 1'b0};
        tbl[3] = '{8'h00, 8'hA5, ANY,  1'b0};
        tbl[4] = '{8'h02, 8'h0F, ANY,  1'b0};
        tbl[5] = '{8'h04, 8'hC3, 1'b0, ANY};
        tbl[6] = '{8'h05, 8'h00, 1'b0, 1'b1};
        tbl[7] = '{8'h07, 8'h7E, 1'b0, 1'b1};
        tbl[8] = '{8'h03, 8'hF9, 1'b1, 1'b0};

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        repeat (3) tick();
        check_all("reset");
        chk("reset_write_strobe", 32'(write_strobe), 32'(0));
        chk("reset_frame_error", 32'(frame_error), 32'(0));
        rst = 1'b0;
        tick();

        // Table frames, one idle cycle between frames.
        for (int i = 0; i < 9; i++) begin
            frame(tbl[i].a, tbl[i].d, tbl[i].f1, tbl[i].f2);
            tick();
        end
        check_all("table");

        // Bad address byte, then a normal frame.
        send(8'h1A);
        tick();
        chk("bad_addr_frame_error", 32'(fe_cnt), 32'(1));
        frame(8'h00, 8'h8F, ANY, 1'b0);
        tick();

        // Timeout: 8 idle cycles abandon the frame; next byte is an address.
        send(8'h07);
        repeat (8) tick();
        send(8'h02);
        chk("timeout_frame_error", 32'(fe_cnt), 32'(2));
        data(3'd2, 8'h11, ANY, 1'b0);
        tick();

        // Data byte on the expiry cycle wins: write, no error.
        send(8'h05);
        repeat (7) tick();
        data(3'd5, 8'h3C, 1'b0, 1'b1);
        tick();
        chk("late_byte_no_error", 32'(fe_cnt), 32'(2));
        repeat (3) tick();

        // Back-to-back frames on consecutive cycles.
        send(8'h01);
        data(3'd1, 8'h88, 1'b1, 1'b0);
        send(8'h05);
        data(3'd5, 8'h88, 1'b0, 1'b1);
        repeat (2) tick();
        check_all("b2b");

        // Reset the cycle after an address byte, with a coincident data byte.
        send(8'h03);
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hFF;
        model_reset();
        tick();
        rst      = 1'b0;
        rx_valid = 1'b0;
        tick();
        check_all("midrst");
        chk("midrst_write_strobe", 32'(write_strobe), 32'(0));

        // Pending address must be gone: 0x04 is an address byte now.
        frame(8'h04, 8'h22, 1'b0, ANY);
        repeat (3) tick();
        check_all("final");
        chk("final_frame_errors", 32'(fe_cnt), 32'(2));
        chk("pending_writes", 32'(sb.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
